// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-ported integer register file with a per-register
// busy scoreboard for issue-stage stall decisions.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   wen           per-port write enable (NWRITE); higher index wins conflicts
//   waddr, wdata  packed write addresses / data, port k at [k*W +: W]
//   raddr         packed read addresses (NREAD)
//   rdata         packed read data, combinational
//   rbusy         busy status per read port, combinational
//   busy_set      mark busy_addr as having an outstanding writeback
//   busy_addr     register to mark busy
//   busy_count    registered number of busy registers
module regfile_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned NWRITE     = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
  input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
  output logic [NREAD*DATA_WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]             rbusy,
  input  logic                         busy_set,
  input  logic [ADDR_WIDTH-1:0]        busy_addr,
  output logic [ADDR_WIDTH:0]          busy_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [CNT_W-1:0]      busy_count_q;
  logic [CNT_W-1:0]      busy_count_d;

  // Per-register write decode; later ports overwrite earlier ones so the
  // highest-index enabled port wins.
  logic [DEPTH-1:0]      wr_hit;
  logic [DATA_WIDTH-1:0] wr_val [DEPTH];

  always_comb begin
    wr_hit = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      wr_val[r] = '0;
    end
    for (int unsigned r = 1; r < DEPTH; r++) begin
      for (int unsigned k = 0; k < NWRITE; k++) begin
        if (wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read ports: r0 is hardwired zero/not busy; a forwarded write is never busy.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned j = 0; j < NREAD; j++) begin
      if (raddr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
        if ((BYPASS != 0) && wr_hit[raddr[j*ADDR_WIDTH +: ADDR_WIDTH]]) begin
          rdata[j*DATA_WIDTH +: DATA_WIDTH] = wr_val[raddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
          rbusy[j] = 1'b0;
        end else begin
          rdata[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
          rbusy[j] = busy_q[raddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

  // Scoreboard next state: writes clear, a new producer's set takes priority.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (busy_set && (busy_addr != '0)) begin
      busy_d[busy_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    busy_count_d = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      busy_count_d = busy_count_d + CNT_W'(busy_d[r]);
    end
  end

  // State update; reset discards same-cycle writes and busy sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      for (int unsigned r = 1; r < DEPTH; r++) begin
        if (wr_hit[r]) begin
          mem_q[r] <= wr_val[r];
        end
      end
    end
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed sequences plus random traffic,
// checked against an array-based reference model through an expectation queue.
module tb_regfile_scoreboard;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int BYP   = 1;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NW-1:0]     wen = '0;
  logic [NW*AW-1:0]  waddr = '0;
  logic [NW*DW-1:0]  wdata = '0;
  logic [NR*AW-1:0]  raddr = '0;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              busy_set = 1'b0;
  logic [AW-1:0]     busy_addr = '0;
  logic [AW:0]       busy_count;

  regfile_scoreboard #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .NWRITE(NW), .BYPASS(BYP)
  ) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rb;
    logic [AW:0]      cnt;
  } exp_t;

  exp_t        q[$];
  logic [DW-1:0] m_reg [DEPTH];
  bit          m_busy [DEPTH];
  bit          m_valid = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Expected outputs for the current model state and the inputs now driven.
  function automatic exp_t predict();
    exp_t e;
    int   cnt;
    e = '0;
    for (int j = 0; j < NR; j++) begin
      int a;
      logic [DW-1:0] d;
      bit b;
      a = int'(raddr[j*AW +: AW]);
      d = m_reg[a];
      b = m_busy[a];
      if (BYP != 0) begin
        for (int k = 0; k < NW; k++) begin
          if (wen[k] && int'(waddr[k*AW +: AW]) == a) begin
            d = wdata[k*DW +: DW];
            b = 1'b0;
          end
        end
      end
      if (a == 0) begin
        d = '0;
        b = 1'b0;
      end
      e.rd[j*DW +: DW] = d;
      e.rb[j] = b;
    end
    cnt = 0;
    for (int r = 0; r < DEPTH; r++) cnt += m_busy[r] ? 1 : 0;
    e.cnt = (AW+1)'(cnt);
    return e;
  endfunction

  // Apply one clock edge to the reference model.
  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_reg[r]  = '0;
        m_busy[r] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      for (int k = 0; k < NW; k++) begin
        int a;
        a = int'(waddr[k*AW +: AW]);
        if (wen[k] && a != 0) begin
          m_reg[a]  = wdata[k*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (busy_set && busy_addr != '0) m_busy[int'(busy_addr)] = 1'b1;
    end
  endtask

  // One cycle: drive inputs just after the edge, queue expectation, advance model.
  task automatic step(input bit r, input logic [1:0] we,
                      input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                      input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input bit bs, input logic [AW-1:0] ba);
    @(posedge clk);
    #1;
    rst = r;
    wen = we;
    waddr = {wa1, wa0};
    wdata = {wd1, wd0};
    raddr = {ra1, ra0};
    busy_set = bs;
    busy_addr = ba;
    if (m_valid) q.push_back(predict());
    model_edge();
  endtask

  task automatic rd(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    step(0, 2'b00, '0, '0, '0, '0, ra0, ra1, 0, '0);
  endtask

  // Monitor: outputs are settled and away from the active edge at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int j = 0; j < NR; j++) begin
          check($sformatf("rdata%0d", j), rdata[j*DW +: DW], e.rd[j*DW +: DW]);
          check($sformatf("rbusy%0d", j), DW'(rbusy[j]), DW'(e.rb[j]));
        end
        check("busy_count", DW'(busy_count), DW'(e.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    // Reset out of unknown state.
    step(1, 2'b00, '0, '0, '0, '0, '0, '0, 0, '0);
    step(1, 2'b00, '0, '0, '0, '0, '0, '0, 0, '0);
    rd(5'd0, 5'd1);

    // Reset clears data, busy bits and count.
    step(0, 2'b01, 5'd5, 32'h1234, '0, '0, 5'd5, 5'd0, 0, '0);
    step(0, 2'b00, '0, '0, '0, '0, 5'd5, 5'd5, 1, 5'd5);
    rd(5'd5, 5'd5);
    step(1, 2'b01, 5'd6, 32'hAAAA, '0, '0, 5'd5, 5'd6, 1, 5'd6);
    rd(5'd5, 5'd6);

    // Register 0: writes and busy_set ignored.
    step(0, 2'b01, 5'd0, 32'hDEADBEEF, '0, '0, 5'd0, 5'd0, 1, 5'd0);
    rd(5'd0, 5'd0);

    // Same-address write conflict: port 1 wins, also via bypass.
    step(0, 2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 5'd3, 5'd0, 0, '0);
    rd(5'd3, 5'd3);

    // Scoreboard set/clear timing on r7.
    step(0, 2'b00, '0, '0, '0, '0, 5'd7, 5'd0, 1, 5'd7);
    rd(5'd7, 5'd7);
    rd(5'd7, 5'd7);
    step(0, 2'b01, 5'd7, 32'h55, '0, '0, 5'd7, 5'd7, 0, '0);
    rd(5'd7, 5'd7);

    // Set and clear to the same register in one cycle: set wins.
    step(0, 2'b00, '0, '0, '0, '0, 5'd9, 5'd0, 1, 5'd9);
    step(0, 2'b10, '0, '0, 5'd9, 32'h99, 5'd9, 5'd0, 1, 5'd9);
    rd(5'd9, 5'd9);

    // Fill the scoreboard completely, then drain two per cycle.
    for (int a = 1; a < DEPTH; a++)
      step(0, 2'b00, '0, '0, '0, '0, AW'(a), 5'd31, 1, AW'(a));
    rd(5'd31, 5'd1);
    rd(5'd16, 5'd0);
    for (int a = 1; a < DEPTH; a += 2) begin
      if (a + 1 < DEPTH)
        step(0, 2'b11, AW'(a), DW'(a * 3), AW'(a + 1), DW'(a * 5), AW'(a), AW'(a + 1), 0, '0);
      else
        step(0, 2'b01, AW'(a), DW'(a * 3), '0, '0, AW'(a), 5'd2, 0, '0);
    end
    rd(5'd31, 5'd30);
    rd(5'd1, 5'd2);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)),
           AW'($urandom_range(0, 7)), $urandom(),
           AW'($urandom_range(0, 7)), $urandom(),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)),
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)));
    end
    rd(5'd0, 5'd1);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
